// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache (32 lines x 32 bytes)
// with its miss-handling FSM, sitting in the MEM stage.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [31:0]    valid;
  logic [31:0]    dirty;
  logic [21:0]    tag_arr  [32];
  logic [255:0]   data_arr [32];
  logic [255:0]   fill_buf;

  logic [21:0]    req_tag;
  logic [4:0]     idx;
  logic [7:0]     word_off;
  logic           req;
  logic           hit;
  logic           store_hit;
  logic           stall;
  logic           unused_bits;

  assign req_tag     = cpu_addr_i[31:10];
  assign idx         = cpu_addr_i[9:5];
  assign word_off    = {cpu_addr_i[4:2], 5'b00000};
  assign unused_bits = ^cpu_addr_i[1:0];
  assign req         = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit         = valid[idx] & (tag_arr[idx] == req_tag);
  assign store_hit   = (state == IDLE) & cpu_MemWrite_i & hit;
  // Stall must vanish the moment reset asserts, even with a request still held.
  assign cpu_stall_o = stall & rst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid    <= 32'h0000_0000;
      dirty    <= 32'h0000_0000;
      fill_buf <= 256'd0;
    end else begin
      if (state == REFILL) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty[idx] <= 1'b1;
      end
      if ((state == ALLOCATE) && mem_ack_i) begin
        fill_buf <= mem_data_i;
      end
    end
  end

  // Tag/data storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (state == REFILL) begin
      data_arr[idx] <= fill_buf;
      tag_arr[idx]  <= req_tag;
    end else if (store_hit) begin
      data_arr[idx][word_off +: 32] <= cpu_data_i;
    end
  end

  always_comb begin
    next_state   = state;
    stall        = 1'b0;
    cpu_data_o   = 32'h0000_0000;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0000_0000;
    mem_data_o   = 256'd0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          stall = 1'b1;
          if (valid[idx] && dirty[idx]) begin
            next_state = WRITEBACK;
          end else begin
            next_state = ALLOCATE;
          end
        end else if (hit && cpu_MemRead_i) begin
          cpu_data_o = data_arr[idx][word_off +: 32];
        end else begin
          cpu_data_o = 32'h0000_0000;
        end
      end
      WRITEBACK: begin
        stall        = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_arr[idx], idx, 5'b00000};
        mem_data_o   = data_arr[idx];
        if (mem_ack_i) begin
          next_state = ALLOCATE;
        end else begin
          next_state = WRITEBACK;
        end
      end
      ALLOCATE: begin
        stall        = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b00000};
        if (mem_ack_i) begin
          next_state = REFILL;
        end else begin
          next_state = ALLOCATE;
        end
      end
      REFILL: begin
        stall      = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized scoreboard bench for dcache_controller: a per-access cache/memory
// reference model predicts loads, memory transactions and stall lengths.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  cpu_addr_i = 32'h0;
  logic [31:0]  cpu_data_i = 32'h0;
  logic         cpu_MemRead_i = 1'b0;
  logic         cpu_MemWrite_i = 1'b0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i = 256'd0;
  logic         mem_ack_i = 1'b0;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mtx_t;

  int total = 0;
  int bad = 0;
  int lat = 3;
  mtx_t         exp_mem[$];
  logic [31:0]  exp_load[$];
  logic [255:0] mem     [int unsigned];
  logic [255:0] ref_mem [int unsigned];
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_line  [32];

  function automatic logic [255:0] dflt(int unsigned la);
    logic [255:0] l;
    logic [31:0] a;
    for (int w = 0; w < 8; w++) begin
      a = (la << 5) | (w << 2);
      l[w*32 +: 32] = a * 32'h9E37_79B1;
    end
    return l;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one call per CPU access; returns the expected stall length.
  function automatic int model(logic [31:0] a, logic [31:0] wd, bit st, bit ld);
    logic [4:0]  i;
    logic [21:0] t;
    int          w;
    int          n;
    int unsigned la;
    i = a[9:5];
    t = a[31:10];
    w = int'(a[4:2]);
    n = 0;
    if (!(m_valid[i] && m_tag[i] == t)) begin
      if (m_valid[i] && m_dirty[i]) begin
        la = {5'b0, m_tag[i], i};
        ref_mem[la] = m_line[i];
        exp_mem.push_back('{1'b1, {m_tag[i], i, 5'b0}, m_line[i]});
        n += lat;
      end
      la = {5'b0, a[31:5]};
      m_line[i] = ref_mem.exists(la) ? ref_mem[la] : dflt(la);
      exp_mem.push_back('{1'b0, {a[31:5], 5'b0}, 256'd0});
      m_valid[i] = 1'b1;
      m_dirty[i] = 1'b0;
      m_tag[i]   = t;
      n += lat + 2;
    end
    if (st) begin
      m_line[i][w*32 +: 32] = wd;
      m_dirty[i] = 1'b1;
    end else if (ld) begin
      exp_load.push_back(m_line[i][w*32 +: 32]);
    end
    return n;
  endfunction

  task automatic access(logic [31:0] a, logic [31:0] wd, bit rd, bit wr);
    int exp_stall;
    int n;
    exp_stall = model(a, wd, wr, rd & !wr);
    cpu_addr_i = a;
    cpu_data_i = wd;
    cpu_MemRead_i = rd;
    cpu_MemWrite_i = wr;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (!cpu_stall_o) break;
      n++;
      if (n > 100) begin
        chk("stall_timeout", 256'(n), 256'(exp_stall));
        break;
      end
    end
    chk("stall_cycles", 256'(n), 256'(exp_stall));
    @(posedge clk_i);
    #1;
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  // Memory responder: ack in the lat-th cycle of each enabled request.
  initial begin
    int cnt;
    int unsigned la;
    cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end
      if (rst_i && mem_enable_o) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ack_i = 1'b1;
          la = {5'b0, mem_addr_o[31:5]};
          if (mem_write_o) mem[la] = mem_data_o;
          else mem_data_i = mem.exists(la) ? mem[la] : dflt(la);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compare memory transactions and load data against the queues.
  initial begin
    mtx_t e;
    logic [31:0] d;
    forever begin
      @(negedge clk_i);
      if (rst_i && mem_enable_o && mem_ack_i) begin
        if (exp_mem.size() == 0) begin
          chk("mem_unexpected", 256'(exp_mem.size()), 256'd1);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_write", 256'(mem_write_o), 256'(e.wr));
          chk("mem_addr", 256'(mem_addr_o), 256'(e.addr));
          if (e.wr) chk("mem_wdata", mem_data_o, e.data);
        end
      end
      if (rst_i && cpu_MemRead_i && !cpu_MemWrite_i && !cpu_stall_o) begin
        if (exp_load.size() == 0) begin
          chk("load_unexpected", 256'(exp_load.size()), 256'd1);
        end else begin
          d = exp_load.pop_front();
          chk("load_data", 256'(cpu_data_o), 256'(d));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] l;
    logic [31:0] a;
    int n;
    int op;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_stall", 256'(cpu_stall_o), 256'd0);
    chk("rst_mem_en", 256'(mem_enable_o), 256'd0);
    chk("rst_mem_wr", 256'(mem_write_o), 256'd0);
    chk("rst_mem_addr", 256'(mem_addr_o), 256'd0);
    chk("rst_mem_data", mem_data_o, 256'd0);
    chk("rst_cpu_data", 256'(cpu_data_o), 256'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    l = dflt(32'd2);
    l[31:0] = 32'hDEAD_BEEF;
    mem[2] = l;
    ref_mem[2] = l;
    lat = 3;
    access(32'h0000_0040, 32'h0, 1'b1, 1'b0);
    access(32'h0000_0044, 32'h1234_5678, 1'b0, 1'b1);
    access(32'h0000_0044, 32'h0, 1'b1, 1'b0);
    lat = 2;
    access(32'h0000_0440, 32'h0, 1'b1, 1'b0);

    mem[32'h40] = 256'd0;
    ref_mem[32'h40] = 256'd0;
    access(32'h0000_0808, 32'hCAFE_0001, 1'b0, 1'b1);
    access(32'h0000_0808, 32'h0, 1'b1, 1'b0);
    access(32'h0000_0C08, 32'h0, 1'b1, 1'b0);

    // Reset in the middle of an ALLOCATE, then the same access misses again.
    lat = 4;
    cpu_addr_i = 32'h0000_02A0;
    cpu_MemRead_i = 1'b1;
    n = 0;
    while (!(mem_enable_o && !mem_write_o) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_reach_alloc", 256'(n < 50), 256'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst_mem_en", 256'(mem_enable_o), 256'd0);
    chk("midrst_stall", 256'(cpu_stall_o), 256'd0);
    cpu_MemRead_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    access(32'h0000_02A0, 32'h0, 1'b1, 1'b0);

    lat = 1;
    access(32'h0000_0044, 32'hA5A5_5A5A, 1'b1, 1'b1);
    access(32'h0000_0044, 32'h0, 1'b1, 1'b0);
    access(32'h0000_0444, 32'h0, 1'b1, 1'b0);

    for (int k = 0; k < 300; k++) begin
      lat = $urandom_range(1, 4);
      op = $urandom_range(0, 4);
      a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if (op == 0) begin
        @(negedge clk_i);
        chk("idle_stall", 256'(cpu_stall_o), 256'd0);
        chk("idle_mem_en", 256'(mem_enable_o), 256'd0);
        @(posedge clk_i);
        #1;
      end else begin
        access(a, $urandom, op != 3, op >= 3);
      end
    end

    repeat (3) @(posedge clk_i);
    chk("mem_left", 256'(exp_mem.size()), 256'd0);
    chk("load_left", 256'(exp_load.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache with its miss-handling FSM, forming the MEM stage directly downstream of the EX/MEM pipeline register. It accepts the registered load/store request (address, store data, MemRead/MemWrite), returns load data to MEM/WB, and talks to a 256-bit-line data memory over a request/acknowledge handshake. On a miss it raises `cpu_stall_o`, which freezes EX/MEM and all earlier stages until the line is resident.

## Interface
- No parameters. Geometry is fixed:
  - 32 lines × 32 bytes.
  - Address split: tag = `addr[31:10]` (22 b), index = `addr[9:5]`, word = `addr[4:2]`; `addr[1:0]` is ignored.
- `clk_i` in 1: clock, all state updates on rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `cpu_addr_i` in 32: byte address (EX/MEM ALU result).
- `cpu_data_i` in 32: store data.
- `cpu_MemRead_i` in 1: load request.
- `cpu_MemWrite_i` in 1: store request.
- `cpu_data_o` out 32: load data; valid when `cpu_MemRead_i` is high and `cpu_stall_o` is low.
- `cpu_stall_o` out 1: pipeline stall request.
- `mem_addr_o` out 32: line-aligned memory address (low 5 bits are 0).
- `mem_data_o` out 256: write-back line data.
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: 1 = line write, 0 = line read.
- `mem_data_i` in 256: fill line, valid in the `mem_ack_i` cycle.
- `mem_ack_i` in 1: one-cycle completion pulse.

## Operation
- **Storage:** per line `valid`, `dirty`, 22-bit tag, 256-bit data. Word *w* occupies data bits `[32w+31:32w]`.
- **Request:** `req = cpu_MemRead_i | cpu_MemWrite_i`. If both are high, the access is treated as a store.
- **Hit:** `valid[idx] & (tag[idx] == addr tag)`.
- **FSM states:** IDLE, WRITEBACK, ALLOCATE, REFILL.
- **IDLE:**
  - No request, or a hit: `cpu_stall_o = 0`.
    - Load hit: `cpu_data_o` is driven combinationally from the array.
    - Store hit: at the clock edge, write the word into the line and set `dirty`.
  - Miss: `cpu_stall_o = 1`.
    - If the victim is valid and dirty, go to WRITEBACK.
    - Otherwise go to ALLOCATE.
- **WRITEBACK:**
  - `mem_enable_o = 1`, `mem_write_o = 1`.
  - `mem_addr_o = {victim tag, idx, 5'b0}`, `mem_data_o` = victim line.
  - Stay until `mem_ack_i`, then go to ALLOCATE.
- **ALLOCATE:**
  - `mem_enable_o = 1`, `mem_write_o = 0`, `mem_addr_o = {req tag, idx, 5'b0}`.
  - On `mem_ack_i`, capture `mem_data_i` into a fill buffer and go to REFILL.
- **REFILL:**
  - Write the fill buffer to the line; set `valid = 1`, `dirty = 0`, tag = request tag.
  - Go to IDLE.
  - The held request then hits in IDLE: a store merges and sets `dirty`; a load returns data.
- **Stall rule:** `cpu_stall_o` is high in WRITEBACK, ALLOCATE and REFILL, and in IDLE on a miss. It is low otherwise.
- **Ignored inputs:** `mem_ack_i` in IDLE or REFILL is ignored. The request inputs are not re-sampled outside IDLE, because EX/MEM is frozen.
- **Memory outputs:** held stable for the whole request and deasserted in the cycle after ack. `mem_enable_o` is never high in IDLE or REFILL.

## Timing
- **Reset** (asynchronous, `rst_i = 0`):
  - State = IDLE; all `valid`/`dirty` bits = 0.
  - `mem_enable_o = 0`, `mem_write_o = 0`, `mem_addr_o = 0`, `mem_data_o = 0`.
  - `cpu_stall_o = 0` (while no request); `cpu_data_o = 0` while no hit.
  - Reset mid-miss abandons the transaction immediately; a late `mem_ack_i` after release is ignored.
- **Hit:** zero added latency; a store updates the array at the same edge at which EX/MEM advances.
- **Clean miss**, with memory ack *L* cycles after enable rises:
  - Cycle 0: IDLE detects the miss.
  - Cycles 1..L: ALLOCATE; ack arrives in cycle L.
  - Cycle L+1: REFILL.
  - Cycle L+2: IDLE hit, stall low.
  - Total stall = L+2 cycles.
- **Dirty miss:** adds WRITEBACK occupancy, *L_wb* cycles. ALLOCATE enable rises in the cycle after the write-back ack, with no dead cycle.
- **Minimum latency:** *L* = 1 (ack in the first enable cycle) must work.

## Test plan
- **Reset, then cold load:** after reset, load `0x0000_0040`; memory returns a line with word0 = `0xDEAD_BEEF`, ack 3 cycles after enable.
  - Stall is high for exactly 5 cycles.
  - `cpu_data_o = 0xDEAD_BEEF`.
  - One memory read at `0x40`.
- **Store hit:** store `0x1234_5678` to `0x44` after the above.
  - No stall.
  - A following load of `0x44` returns `0x1234_5678`, with no memory traffic.
- **Dirty eviction:** load `0x0000_0440`, which has the same index as `0x40` and a different tag.
  - Memory write at `0x40` whose line word1 = `0x1234_5678`.
  - Then a memory read at `0x440`.
  - Stall is released after REFILL.
- **Store miss allocate:** store `0xCAFE_0001` to `0x0000_0808`; memory line is all zero.
  - Memory read at `0x800`.
  - After the stall, reading `0x808` returns `0xCAFE_0001` and the line is dirty.
  - Evicting it via `0x0C08` produces a write-back of that word.
- **Reset mid-miss:** assert `rst_i = 0` while in ALLOCATE.
  - `mem_enable_o` and `cpu_stall_o` drop immediately.
  - A re-access of the same address misses again.
- **Read+write both high, and ack with L = 1:** store semantics are applied; the FSM timing holds with a single-cycle ack.
